mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Instruction fetch stage of the multi-cycle MIPS datapath. It sits directly upstream of the main controller.
- Holds the PC and runs a request/acknowledge fetch from instruction memory.
- Latches the fetched word into an instruction register and presents the decoded fields (op, order_func, register and immediate fields) to the controller and datapath.
- When the downstream stage signals completion, it computes the next PC from the controller's beq/j/jal/jr outputs plus the ALU zero flag.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- im_req  out  1  instruction-memory read request
- im_addr  out  32  word address to read; equals pc
- im_ack  in  1  memory returns im_rdata this cycle
- im_rdata  in  32  instruction word
- advance  in  1  downstream has finished the current instruction
- beq  in  1  controller: branch-on-equal instruction
- zero  in  1  ALU equal/zero flag
- j  in  1  controller: jump
- jal  in  1  controller: jump-and-link
- jr  in  1  controller: jump register
- jr_target  in  32  GPR[rs] value for jr
- instr  out  32  instruction register
- instr_valid  out  1  instr holds a valid instruction awaiting execution
- op  out  6  instr[31:26]
- order_func  out  6  instr[5:0]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd_addr  out  5  instr[15:11]
- imm16  out  16  instr[15:0]
- imm26  out  26  instr[25:0]
- pc  out  32  address of the instruction in instr / being fetched
- pc_plus4  out  32  pc + 4, for the jal link value
- addr_err  out  1  one-cycle pulse: misaligned jr target

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=PC_RESET, instr=0, instr_valid=0, addr_err=0.
  - State=FETCH. im_req is combinational from state, so it is 1 while in FETCH, including during reset.
  - Reset mid-fetch or mid-execute abandons the operation. No ack is retained.
- State FETCH:
  - im_req=1, im_addr=pc. im_addr is stable while im_req=1.
  - On im_ack=1: instr<=im_rdata, instr_valid<=1, go to EXEC.
  - An ack in the same cycle as the first request is legal. instr_valid is then 1 on the next edge, giving a minimum 1-cycle fetch latency.
- State EXEC:
  - im_req=0, instr stable, instr_valid=1.
  - On advance=1: pc<=npc, instr_valid<=0, go to FETCH.
  - beq/zero/j/jal/jr/jr_target are sampled only on this edge.
- Field outputs are combinational slices of instr. pc_plus4 = pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- npc priority (highest first):
  - jr: {jr_target[31:2],2'b00}. If jr_target[1:0]!=0, addr_err=1 for exactly the cycle after the update.
  - j or jal: {pc_plus4[31:28], imm26, 2'b00}.
  - beq & zero: pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32.
  - otherwise: pc_plus4.
- Simultaneous j and jr: jr wins.
- beq with zero=0 falls through to pc_plus4.
- Ignored events:
  - im_ack outside FETCH has no effect.
  - advance outside EXEC has no effect.
  - An advance asserted during FETCH is not remembered.
- No instruction is lost or duplicated. Each instruction is presented with instr_valid=1 until exactly one advance is accepted.

Test Plan:
- Reset then ack next cycle with im_rdata=32'h2008_0005 → im_req=1, im_addr=32'h3000 during reset; after ack, op=6'h08, rt=8, imm16=5, instr_valid=1. advance → pc=32'h3004, FETCH.
- beq with imm16=16'hFFFF at pc=32'h3010: zero=1 → pc=32'h3010. zero=0 → pc=32'h3014.
- jal with imm26=26'h0000C10, pc=32'h3020 → pc=32'h0000_3040, pc_plus4=32'h3024 while in EXEC. j and jr both asserted, jr_target=32'h0000_3100 → pc=32'h3100.
- jr_target=32'h0000_3006 → pc=32'h3004, addr_err high for exactly one cycle.
- Memory wait of 5 cycles → im_req and im_addr held constant for 5 cycles. Spurious advance during the wait ignored. Spurious im_ack in EXEC ignored; instr unchanged.
- rst_n pulled low mid-EXEC at pc=32'h3040 → instr_valid=0, pc=32'h3000 immediately (async), fetch restarts. pc=32'hFFFF_FFFC with no branch → pc=0 after advance.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage of the multi-cycle MIPS datapath: PC, req/ack fetch,
// instruction register with decoded fields, and next-PC selection on advance.
module mips_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    input  logic        advance,
    input  logic        beq,
    input  logic        zero,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  order_func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd_addr,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        addr_err_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] npc_s;
    logic        jr_misaligned_s;

    assign pc_plus4_s  = pc_r + 32'd4;

    // Request is decoded from state so it is already high while reset is held.
    assign im_req      = (state_r == FETCH);
    assign im_addr     = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign addr_err    = addr_err_r;
    assign op          = instr_r[31:26];
    assign rs          = instr_r[25:21];
    assign rt          = instr_r[20:16];
    assign rd_addr     = instr_r[15:11];
    assign order_func  = instr_r[5:0];
    assign imm16       = instr_r[15:0];
    assign imm26       = instr_r[25:0];

    // Next-PC selection: jr beats j/jal, which beat a taken beq.
    always_comb begin
        npc_s           = pc_plus4_s;
        jr_misaligned_s = 1'b0;
        if (jr) begin
            npc_s           = {jr_target[31:2], 2'b00};
            jr_misaligned_s = (jr_target[1:0] != 2'b00);
        end else if (j || jal) begin
            npc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
        end else if (beq && zero) begin
            npc_s = pc_plus4_s + {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
        end else begin
            npc_s = pc_plus4_s;
        end
    end

    // Fetch/execute sequencing; addr_err is a single-cycle pulse after a bad jr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH;
            pc_r          <= PC_RESET;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            addr_err_r    <= 1'b0;
        end else begin
            addr_err_r <= 1'b0;
            case (state_r)
                FETCH: begin
                    if (im_ack) begin
                        instr_r       <= im_rdata;
                        instr_valid_r <= 1'b1;
                        state_r       <= EXEC;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        pc_r          <= npc_s;
                        instr_valid_r <= 1'b0;
                        addr_err_r    <= jr_misaligned_s;
                        state_r       <= FETCH;
                    end else begin
                        state_r <= EXEC;
                    end
                end
                default: begin
                    state_r       <= FETCH;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: fetches push expected {pc, word},
// a monitor pops and compares each time a new instruction is presented.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        advance;
    logic        beq;
    logic        zero;
    logic        j;
    logic        jal;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic [5:0]  order_func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_addr;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;

    mips_fetch_unit #(.PC_RESET(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr),
        .im_ack(im_ack), .im_rdata(im_rdata), .advance(advance), .beq(beq),
        .zero(zero), .j(j), .jal(jal), .jr(jr), .jr_target(jr_target),
        .instr(instr), .instr_valid(instr_valid), .op(op), .order_func(order_func),
        .rs(rs), .rt(rt), .rd_addr(rd_addr), .imm16(imm16), .imm26(imm26),
        .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new instr_valid rise is checked against the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_instr", instr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", instr, e.word);
                chk("sb_pc", pc, e.pc);
            end
        end
        prev_valid = instr_valid;
    end

    // Fetch one word at exp_pc after wait_cycles of no ack, optionally with a stray advance.
    task automatic fetch(input logic [31:0] word, input int wait_cycles,
                         input logic [31:0] exp_pc, input logic spur_adv);
        sb.push_back('{pc: exp_pc, word: word});
        for (int i = 0; i < wait_cycles; i++) begin
            chk("wait_im_req", {31'd0, im_req}, 32'd1);
            chk("wait_im_addr", im_addr, exp_pc);
            advance = spur_adv;
            @(posedge clk);
            #1;
        end
        advance  = 1'b0;
        im_ack   = 1'b1;
        im_rdata = word;
        @(posedge clk);
        #1;
        im_ack   = 1'b0;
        im_rdata = 32'h0000_0000;
    endtask

    task automatic do_advance(input logic b, input logic z, input logic jj,
                              input logic jl, input logic r, input logic [31:0] tgt);
        beq = b; zero = z; j = jj; jal = jl; jr = r; jr_target = tgt;
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0; beq = 1'b0; zero = 1'b0; j = 1'b0; jal = 1'b0; jr = 1'b0;
        jr_target = 32'h0000_0000;
    endtask

    initial begin
        rst_n = 1'b1; im_ack = 1'b0; im_rdata = 32'h0000_0000; advance = 1'b0;
        beq = 1'b0; zero = 1'b0; j = 1'b0; jal = 1'b0; jr = 1'b0;
        jr_target = 32'h0000_0000;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_im_req", {31'd0, im_req}, 32'd1);
        chk("rst_im_addr", im_addr, 32'h0000_3000);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi $t0,$zero,5 with a single-cycle fetch
        fetch(32'h2008_0005, 0, 32'h0000_3000, 1'b0);
        chk("addi_op", {26'd0, op}, 32'h08);
        chk("addi_rt", {27'd0, rt}, 32'd8);
        chk("addi_imm16", {16'd0, imm16}, 32'd5);
        chk("addi_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_im_req", {31'd0, im_req}, 32'd0);
        do_advance(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_pc", pc, 32'h0000_3004);
        chk("seq_fetch", {31'd0, im_req}, 32'd1);

        // j to 0x3010, then beq -1 taken / not taken
        fetch(32'h0800_0C04, 0, 32'h0000_3004, 1'b0);
        do_advance(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("j_pc", pc, 32'h0000_3010);
        fetch(32'h1000_FFFF, 0, 32'h0000_3010, 1'b0);
        do_advance(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("beq_taken_pc", pc, 32'h0000_3010);
        fetch(32'h1000_FFFF, 0, 32'h0000_3010, 1'b0);
        do_advance(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("beq_not_taken_pc", pc, 32'h0000_3014);

        // j to 0x3020, jal imm26=0xC10
        fetch(32'h0800_0C08, 0, 32'h0000_3014, 1'b0);
        do_advance(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        fetch(32'h0C00_0C10, 0, 32'h0000_3020, 1'b0);
        chk("jal_pc_plus4", pc_plus4, 32'h0000_3024);
        do_advance(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("jal_pc", pc, 32'h0000_3040);

        // j and jr together: jr wins
        fetch(32'h0800_0001, 0, 32'h0000_3040, 1'b0);
        do_advance(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3100);
        chk("jr_over_j_pc", pc, 32'h0000_3100);
        chk("jr_aligned_err", {31'd0, addr_err}, 32'd0);

        // misaligned jr
        fetch(32'h03E0_0008, 0, 32'h0000_3100, 1'b0);
        do_advance(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3006);
        chk("jr_mis_pc", pc, 32'h0000_3004);
        chk("jr_mis_err", {31'd0, addr_err}, 32'd1);
        @(posedge clk);
        #1;
        chk("jr_mis_err_clear", {31'd0, addr_err}, 32'd0);

        // 5-cycle memory wait with stray advance, then stray ack in EXEC
        fetch(32'h0000_0020, 5, 32'h0000_3004, 1'b1);
        chk("wait_pc_hold", pc, 32'h0000_3004);
        @(posedge clk);
        #1;
        chk("adv_not_remembered", {31'd0, instr_valid}, 32'd1);
        im_ack = 1'b1; im_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        im_ack = 1'b0; im_rdata = 32'h0000_0000;
        chk("stray_ack_instr", instr, 32'h0000_0020);
        do_advance(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("after_wait_pc", pc, 32'h0000_3008);

        // reset while executing at 0x3040
        fetch(32'h0800_0C10, 0, 32'h0000_3008, 1'b0);
        do_advance(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        fetch(32'h0000_0021, 0, 32'h0000_3040, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_exec_pc", pc, 32'h0000_3000);
        chk("rst_exec_req", {31'd0, im_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // jr to 0xFFFF_FFFC, then fall-through wraps to 0
        fetch(32'h03E0_0008, 0, 32'h0000_3000, 1'b0);
        do_advance(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        do_advance(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
